// File: rtl/im_arb_pkg.sv
// Shared types and default sizing for the instruction-memory port arbiter.
// Also imported by the fetch-stage bench.
package im_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LD_ACC = 2'd2
    } arb_state_t;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_LD_BURST_MAX = 4;
    localparam int DEF_TIMEOUT_CYC  = 64;

endpackage

// File: rtl/im_arb_timer.sv
// Per-access timeout down-counter. Loaded at grant; expire fires on the last waiting cycle.
module im_arb_timer
    import im_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Counts down from TIMEOUT_CYC-1 and saturates at zero rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = count_en && (cnt == '0);

endmodule

// File: rtl/im_access_arbiter.sv
// Shares the single instruction-memory port between IF fetch and the loader/debug port,
// with redirect kill, loader burst fairness and access timeout.
//
// state  | meaning
// IDLE   | port free; arbitration happens here, one cycle between accesses
// IF_ACC | fetch request outstanding on the memory port
// LD_ACC | loader read/write outstanding on the memory port
module im_access_arbiter
    import im_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int LD_BURST_MAX = DEF_LD_BURST_MAX,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_valid_o,
    output logic                  stall_if_o,
    input  logic                  ld_req_i,
    input  logic                  ld_we_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_wdata_i,
    output logic [DATA_WIDTH-1:0] ld_rdata_o,
    output logic                  ld_done_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic                  timeout_o
);

    localparam int BW = $clog2(LD_BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(LD_BURST_MAX);

    arb_state_t            state_q, state_d;
    logic                  mem_req_d, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d, if_rdata_d, ld_rdata_d;
    logic                  if_valid_d, ld_done_d, timeout_d;
    logic                  kill_q, kill_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic                  grant_if, grant_ld, acc_end, expire;

    im_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (grant_if || grant_ld),
        .clear    (acc_end),
        .count_en (mem_req_o && !mem_ready_i),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_valid_o  <= 1'b0;
            if_rdata_o  <= '0;
            ld_done_o   <= 1'b0;
            ld_rdata_o  <= '0;
            timeout_o   <= 1'b0;
            kill_q      <= 1'b0;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_o   <= mem_req_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            if_valid_o  <= if_valid_d;
            if_rdata_o  <= if_rdata_d;
            ld_done_o   <= ld_done_d;
            ld_rdata_o  <= ld_rdata_d;
            timeout_o   <= timeout_d;
            kill_q      <= kill_d;
            burst_q     <= burst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_o;
        mem_we_d    = mem_we_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_o;
        ld_done_d   = 1'b0;
        ld_rdata_d  = ld_rdata_o;
        timeout_d   = timeout_o;
        kill_d      = kill_q;
        grant_if    = 1'b0;
        grant_ld    = 1'b0;
        acc_end     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ld_req_i && burst_q < BURST_LIM) begin
                    grant_ld = 1'b1;
                end else if (if_req_i && !flush_i) begin
                    grant_if = 1'b1;
                end else if (ld_req_i) begin
                    grant_ld = 1'b1;
                end
                if (grant_ld) begin
                    state_d     = LD_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ld_we_i;
                    mem_addr_d  = ld_addr_i;
                    mem_wdata_d = ld_we_i ? ld_wdata_i : '0;
                end else if (grant_if) begin
                    state_d     = IF_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                end
            end
            IF_ACC, LD_ACC: begin
                if (state_q == IF_ACC && flush_i) begin
                    kill_d = 1'b1;
                end
                if (mem_ready_i || expire) begin
                    acc_end = 1'b1;
                end
                if (mem_ready_i) begin
                    // A redirect arriving with the data still discards it.
                    if (state_q == IF_ACC && !kill_q && !flush_i) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end else if (state_q == LD_ACC) begin
                        ld_done_d  = 1'b1;
                        ld_rdata_d = mem_we_o ? '0 : mem_rdata_i;
                    end
                end else if (expire) begin
                    timeout_d = 1'b1;
                end
                if (acc_end) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    kill_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        burst_d = burst_q;
        if (!if_req_i || grant_if) begin
            burst_d = '0;
        end else if (grant_ld && burst_q != BURST_LIM) begin
            burst_d = burst_q + 1'b1;
        end
    end

    // Reset forces the stall low too, so every output is quiet while rst is asserted.
    assign stall_if_o = rst && ((if_req_i && !if_valid_o) || state_q == LD_ACC);

endmodule

// File: tb/tb_im_access_arbiter.sv
// Directed bench for im_access_arbiter: fetch latency, zero-wait streaming, redirect kill,
// loader fairness, loader write/read, timeout and asynchronous reset.
module tb_im_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, flush_i, ld_req_i, ld_we_i, mem_ready_i;
    logic [7:0]  if_addr_i, ld_addr_i;
    logic [15:0] ld_wdata_i, mem_rdata_i, rdata_drv;
    logic [15:0] if_rdata_o, ld_rdata_o, mem_wdata_o;
    logic        if_valid_o, stall_if_o, ld_done_o, mem_req_o, mem_we_o, timeout_o;
    logic [7:0]  mem_addr_o;
    logic        use_model;
    logic [15:0] tb_mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    im_access_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .flush_i     (flush_i),
        .if_rdata_o  (if_rdata_o),
        .if_valid_o  (if_valid_o),
        .stall_if_o  (stall_if_o),
        .ld_req_i    (ld_req_i),
        .ld_we_i     (ld_we_i),
        .ld_addr_i   (ld_addr_i),
        .ld_wdata_i  (ld_wdata_i),
        .ld_rdata_o  (ld_rdata_o),
        .ld_done_o   (ld_done_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .timeout_o   (timeout_o)
    );

    // Simple memory used by the loader write/read scenario.
    always @(posedge clk) begin
        if (mem_req_o && mem_ready_i && mem_we_o) tb_mem[mem_addr_o] <= mem_wdata_o;
    end
    assign mem_rdata_i = use_model ? tb_mem[mem_addr_o] : rdata_drv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req_i = 0; flush_i = 0; ld_req_i = 0; ld_we_i = 0; mem_ready_i = 0;
        if_addr_i = '0; ld_addr_i = '0; ld_wdata_i = '0; rdata_drv = '0; use_model = 0;
        tick(); tick();
        total++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== 8'h00 || mem_wdata_o !== 16'h0) begin
            bad++; $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, want all 0", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        total++;
        if (if_valid_o !== 1'b0 || if_rdata_o !== 16'h0 || stall_if_o !== 1'b0) begin
            bad++; $display("FAIL reset_if: valid=%b rdata=%h stall=%b, want all 0", if_valid_o, if_rdata_o, stall_if_o);
        end
        total++;
        if (ld_done_o !== 1'b0 || ld_rdata_o !== 16'h0 || timeout_o !== 1'b0) begin
            bad++; $display("FAIL reset_ld: done=%b rdata=%h timeout=%b, want all 0", ld_done_o, ld_rdata_o, timeout_o);
        end
        rst = 1'b1;
        tick();
        total++;
        if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_idle_req: got %b want 0", mem_req_o); end
    endtask

    task automatic test_fetch_latency();
        if_req_i = 1; if_addr_i = 8'h10;
        #1;
        total++;
        if (stall_if_o !== 1'b1) begin bad++; $display("FAIL fetch_stall_pre: got %b want 1", stall_if_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 8'h10 || mem_we_o !== 1'b0) begin
                bad++; $display("FAIL fetch_req_c%0d: req=%b addr=%h we=%b want 1/10/0", i, mem_req_o, mem_addr_o, mem_we_o);
            end
            total++;
            if (stall_if_o !== 1'b1 || if_valid_o !== 1'b0) begin
                bad++; $display("FAIL fetch_stall_c%0d: stall=%b valid=%b want 1/0", i, stall_if_o, if_valid_o);
            end
            if (i == 0) if_addr_i = 8'h77;
            if (i == 2) begin mem_ready_i = 1; rdata_drv = 16'hA5A5; end
            tick();
        end
        total++;
        if (mem_req_o !== 1'b0 || if_valid_o !== 1'b1 || if_rdata_o !== 16'hA5A5 || stall_if_o !== 1'b0) begin
            bad++; $display("FAIL fetch_done: req=%b valid=%b rdata=%h stall=%b want 0/1/a5a5/0", mem_req_o, if_valid_o, if_rdata_o, stall_if_o);
        end
        mem_ready_i = 0; if_req_i = 0;
        tick();
        total++;
        if (if_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            bad++; $display("FAIL fetch_single_pulse: valid=%b req=%b want 0/0", if_valid_o, mem_req_o);
        end
    endtask

    task automatic test_zero_wait();
        int pulses = 0;
        mem_ready_i = 1; rdata_drv = 16'h3C3C; if_req_i = 1; if_addr_i = 8'h30;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (if_valid_o !== (k % 2 == 0) || stall_if_o !== (k % 2 != 0)) begin
                bad++; $display("FAIL zero_wait_e%0d: valid=%b stall=%b want %b/%b", k, if_valid_o, stall_if_o, k % 2 == 0, k % 2 != 0);
            end
            if (if_valid_o === 1'b1) begin
                pulses++;
                total++;
                if (if_rdata_o !== 16'h3C3C) begin bad++; $display("FAIL zero_wait_data: got %h want 3c3c", if_rdata_o); end
            end
        end
        total++;
        if (pulses != 4) begin bad++; $display("FAIL zero_wait_pulses: got %0d want 4", pulses); end
        if_req_i = 0; mem_ready_i = 0;
        tick();
    endtask

    task automatic test_flush();
        if_req_i = 1; if_addr_i = 8'h20;
        tick();
        tick();
        flush_i = 1; if_addr_i = 8'h40;
        tick();
        flush_i = 0;
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 8'h20) begin
            bad++; $display("FAIL flush_hold: req=%b addr=%h want 1/20", mem_req_o, mem_addr_o);
        end
        mem_ready_i = 1; rdata_drv = 16'hDEAD;
        tick();
        total++;
        if (if_valid_o !== 1'b0 || mem_req_o !== 1'b0 || stall_if_o !== 1'b1) begin
            bad++; $display("FAIL flush_killed: valid=%b req=%b stall=%b want 0/0/1", if_valid_o, mem_req_o, stall_if_o);
        end
        mem_ready_i = 0;
        tick();
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 8'h40) begin
            bad++; $display("FAIL flush_refetch: req=%b addr=%h want 1/40", mem_req_o, mem_addr_o);
        end
        mem_ready_i = 1; rdata_drv = 16'h4040;
        tick();
        total++;
        if (if_valid_o !== 1'b1 || if_rdata_o !== 16'h4040) begin
            bad++; $display("FAIL flush_new_data: valid=%b rdata=%h want 1/4040", if_valid_o, if_rdata_o);
        end
        if_req_i = 0; mem_ready_i = 0;
        tick();
        // Same-cycle flush and ready also suppresses the completion.
        if_req_i = 1; if_addr_i = 8'h22;
        tick();
        mem_ready_i = 1; flush_i = 1; rdata_drv = 16'hBAD0;
        tick();
        flush_i = 0; mem_ready_i = 0; if_req_i = 0;
        total++;
        if (if_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            bad++; $display("FAIL flush_same_cycle: valid=%b req=%b want 0/0", if_valid_o, mem_req_o);
        end
        tick();
    endtask

    task automatic test_burst();
        logic [7:0] exp_order [6];
        logic [7:0] got_order [6];
        int n = 0;
        int dones = 0;
        int valids = 0;
        exp_order = '{8'h60, 8'h60, 8'h60, 8'h60, 8'h50, 8'h60};
        got_order = '{default: 8'h00};
        mem_ready_i = 1; rdata_drv = 16'h1234;
        if_req_i = 1; if_addr_i = 8'h50; ld_req_i = 1; ld_we_i = 0; ld_addr_i = 8'h60;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (mem_req_o === 1'b1 && n < 6) begin got_order[n] = mem_addr_o; n++; end
            if (ld_done_o === 1'b1) dones++;
            if (if_valid_o === 1'b1) valids++;
            total++;
            if (stall_if_o !== (k != 10)) begin
                bad++; $display("FAIL burst_stall_e%0d: got %b want %b", k, stall_if_o, k != 10);
            end
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (got_order[i] !== exp_order[i]) begin
                bad++; $display("FAIL burst_order_%0d: addr=%h want %h", i, got_order[i], exp_order[i]);
            end
        end
        total++;
        if (dones != 5 || valids != 1) begin
            bad++; $display("FAIL burst_counts: ld_done=%0d if_valid=%0d want 5/1", dones, valids);
        end
        if_req_i = 0; ld_req_i = 0; mem_ready_i = 0;
        tick();
    endtask

    task automatic test_loader_rw();
        int dones = 0;
        use_model = 1;
        ld_req_i = 1; ld_we_i = 1; ld_addr_i = 8'h05; ld_wdata_i = 16'hBEEF;
        tick();
        total++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 8'h05 || mem_wdata_o !== 16'hBEEF) begin
            bad++; $display("FAIL ld_write_req: req=%b we=%b addr=%h wdata=%h want 1/1/05/beef", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        ld_req_i = 0; ld_wdata_i = 16'h0000; mem_ready_i = 1;
        tick();
        if (ld_done_o === 1'b1) dones++;
        total++;
        if (ld_done_o !== 1'b1 || ld_rdata_o !== 16'h0) begin
            bad++; $display("FAIL ld_write_done: done=%b rdata=%h want 1/0000", ld_done_o, ld_rdata_o);
        end
        ld_req_i = 1; ld_we_i = 0;
        tick();
        total++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 8'h05) begin
            bad++; $display("FAIL ld_read_req: req=%b we=%b addr=%h want 1/0/05", mem_req_o, mem_we_o, mem_addr_o);
        end
        ld_req_i = 0;
        tick();
        if (ld_done_o === 1'b1) dones++;
        total++;
        if (ld_done_o !== 1'b1 || ld_rdata_o !== 16'hBEEF || dones != 2) begin
            bad++; $display("FAIL ld_read_done: done=%b rdata=%h pulses=%0d want 1/beef/2", ld_done_o, ld_rdata_o, dones);
        end
        mem_ready_i = 0; use_model = 0;
        tick();
    endtask

    task automatic test_timeout_and_reset();
        int hi = 0;
        mem_ready_i = 0; if_req_i = 1; if_addr_i = 8'h70;
        tick();
        for (int i = 0; i < 200; i++) begin
            if (mem_req_o !== 1'b1) break;
            hi++;
            tick();
        end
        if_req_i = 0;
        total++;
        if (hi != 64) begin bad++; $display("FAIL timeout_len: req high %0d cycles want 64", hi); end
        total++;
        if (timeout_o !== 1'b1 || if_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            bad++; $display("FAIL timeout_abort: timeout=%b valid=%b req=%b want 1/0/0", timeout_o, if_valid_o, mem_req_o);
        end
        tick(); tick();
        total++;
        if (timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", timeout_o); end
        if_req_i = 1; if_addr_i = 8'h71;
        tick();
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 8'h71) begin
            bad++; $display("FAIL timeout_then_idle: req=%b addr=%h want 1/71", mem_req_o, mem_addr_o);
        end
        rst = 1'b0;
        #1;
        total++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 8'h00 || timeout_o !== 1'b0 || stall_if_o !== 1'b0 || if_valid_o !== 1'b0) begin
            bad++; $display("FAIL async_reset: req=%b addr=%h timeout=%b stall=%b valid=%b want all 0", mem_req_o, mem_addr_o, timeout_o, stall_if_o, if_valid_o);
        end
        mem_ready_i = 1; rdata_drv = 16'h7171;
        tick();
        if_req_i = 0; mem_ready_i = 0; rst = 1'b1;
        tick();
        total++;
        if (if_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            bad++; $display("FAIL reset_no_completion: valid=%b req=%b want 0/0", if_valid_o, mem_req_o);
        end
        if_req_i = 1; if_addr_i = 8'h72;
        tick();
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 8'h72) begin
            bad++; $display("FAIL reset_restart: req=%b addr=%h want 1/72", mem_req_o, mem_addr_o);
        end
        mem_ready_i = 1; rdata_drv = 16'h7272;
        tick();
        total++;
        if (if_valid_o !== 1'b1 || if_rdata_o !== 16'h7272) begin
            bad++; $display("FAIL reset_restart_data: valid=%b rdata=%h want 1/7272", if_valid_o, if_rdata_o);
        end
        if_req_i = 0; mem_ready_i = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_latency();
        test_zero_wait();
        test_flush();
        test_burst();
        test_loader_rw();
        test_timeout_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
